// File: rtl/spad_w_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : spad_w_seq_if
//  Description : Bundle of the weight-stream, SPAD_W control and PE handshake
//                signals around the weight scratchpad sequencer.
//                master : sequencer side (accepts weights, drives SPAD and PE)
//                slave  : environment side (weight source, SPAD, PE)
//  Signals     : w_valid/w_data/w_ready    upstream weight stream
//                spad_we_en/spad_addr_we/spad_data_in/spad_addr_re  SPAD_W
//                pe_valid/pe_ready/pe_last PE weight handshake
//  Revision    : 1.0  initial release
// ============================================================================
interface spad_w_seq_if #(
    parameter int WEIGHT_DW = 32,
    parameter int AW        = 3
) ();
    logic                 w_valid;
    logic [WEIGHT_DW-1:0] w_data;
    logic                 w_ready;
    logic                 spad_we_en;
    logic [AW-1:0]        spad_addr_we;
    logic [WEIGHT_DW-1:0] spad_data_in;
    logic [AW-1:0]        spad_addr_re;
    logic                 pe_valid;
    logic                 pe_ready;
    logic                 pe_last;

    modport master (
        input  w_valid, w_data, pe_ready,
        output w_ready, spad_we_en, spad_addr_we, spad_data_in,
               spad_addr_re, pe_valid, pe_last
    );

    modport slave (
        output w_valid, w_data, pe_ready,
        input  w_ready, spad_we_en, spad_addr_we, spad_data_in,
               spad_addr_re, pe_valid, pe_last
    );
endinterface
`default_nettype wire

// File: rtl/spad_w_seq.sv
`default_nettype none
// ============================================================================
//  Module      : spad_w_seq
//  Description : Sequencer for one weight scratchpad. Loads n = min(num_w,
//                DEPTH) weights from the upstream stream into the SPAD, then
//                replays them in address order p = max(num_pass,1) times to
//                the PE. Reads never overlap writes: LOAD and READ are
//                separate phases.
//  Ports       : sclk      clock, all logic on posedge
//                rst       synchronous reset, active-high
//                start     start pulse, sampled only when idle
//                num_w     weights to load/replay, sampled with start
//                num_pass  replay passes, sampled with start
//                bus       spad_w_seq_if.master (stream, SPAD, PE signals)
//                busy      sequencer not idle
//                done      one-cycle completion pulse
//  Revision    : 1.0  initial release
// ============================================================================
module spad_w_seq #(
    parameter int WEIGHT_DW = 32,
    parameter int DEPTH     = 8,
    parameter int PASS_W    = 8,
    parameter int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  wire              sclk,
    input  wire              rst,
    input  wire              start,
    input  wire [AW:0]       num_w,
    input  wire [PASS_W-1:0] num_pass,
    spad_w_seq_if.master     bus,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_READ = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [AW:0]       c_depth_n = (AW+1)'(DEPTH);
    localparam logic [AW:0]       c_one_n   = (AW+1)'(1);
    localparam logic [AW-1:0]     c_one_a   = AW'(1);
    localparam logic [PASS_W-1:0] c_one_p   = PASS_W'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AW:0]         r_n;
    logic [PASS_W-1:0]   r_p;
    logic [AW-1:0]       r_wr_cnt;
    logic [AW-1:0]       r_rd_cnt;
    logic [PASS_W-1:0]   r_pass_cnt;

    logic [AW:0]         w_n_clamp;
    logic [PASS_W-1:0]   w_p_clamp;
    logic [AW:0]         w_n_last;
    logic                w_wr_last;
    logic                w_rd_last;
    logic                w_pass_last;
    logic                w_wr_acc;
    logic                w_rd_acc;

    // Job size is fixed at start: n saturates at DEPTH, zero passes means one.
    assign w_n_clamp = (num_w > c_depth_n) ? c_depth_n : num_w;
    assign w_p_clamp = (num_pass == '0) ? c_one_p : num_pass;

    // n can equal DEPTH, so compare in AW+1 bits against n-1.
    assign w_n_last    = r_n - c_one_n;
    assign w_wr_last   = ({1'b0, r_wr_cnt} == w_n_last);
    assign w_rd_last   = ({1'b0, r_rd_cnt} == w_n_last);
    assign w_pass_last = (r_pass_cnt == (r_p - c_one_p));

    assign w_wr_acc = (r_state == S_LOAD) && bus.w_valid;
    assign w_rd_acc = (r_state == S_READ) && bus.pe_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        bus.w_ready      = 1'b0;
        bus.spad_we_en   = 1'b0;
        bus.spad_addr_we = '0;
        bus.spad_data_in = '0;
        bus.spad_addr_re = '0;
        bus.pe_valid     = 1'b0;
        bus.pe_last      = 1'b0;
        busy             = (r_state != S_IDLE);
        done             = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    // An empty job skips the SPAD entirely.
                    w_state_nxt = (w_n_clamp == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                bus.w_ready      = 1'b1;
                bus.spad_we_en   = bus.w_valid;
                bus.spad_addr_we = r_wr_cnt;
                bus.spad_data_in = bus.w_data;
                if (bus.w_valid && w_wr_last) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                // The SPAD read port is combinational on addr_re, so holding
                // rd_cnt during a stall keeps the weight stable for the PE.
                bus.spad_addr_re = r_rd_cnt;
                bus.pe_valid     = 1'b1;
                bus.pe_last      = w_rd_last && w_pass_last;
                if (bus.pe_ready && w_rd_last && w_pass_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Job parameters and counters
    // ------------------------------------------------------------------
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_n        <= '0;
            r_p        <= '0;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_pass_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n <= w_n_clamp;
                        r_p <= w_p_clamp;
                    end
                end
                S_LOAD: begin
                    if (w_wr_acc) begin
                        r_wr_cnt <= w_wr_last ? '0 : (r_wr_cnt + c_one_a);
                    end
                end
                S_READ: begin
                    if (w_rd_acc) begin
                        if (w_rd_last) begin
                            r_rd_cnt   <= '0;
                            // Clearing on the final pass leaves the counters
                            // ready for the next job.
                            r_pass_cnt <= w_pass_last ? '0 : (r_pass_cnt + c_one_p);
                        end else begin
                            r_rd_cnt <= r_rd_cnt + c_one_a;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spad_w_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spad_w_seq
//  Description : Self-checking bench for spad_w_seq. A table of jobs with
//                hand-derived totals plus randomized jobs; every cycle the
//                outputs are compared to a transfer-counting reference model
//                and the PE data is read from a behavioural SPAD.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spad_w_seq;

    localparam int WEIGHT_DW = 32;
    localparam int DEPTH     = 8;
    localparam int PASS_W    = 8;
    localparam int AW        = 3;

    logic              sclk = 1'b0;
    logic              rst;
    logic              start;
    logic [AW:0]       num_w;
    logic [PASS_W-1:0] num_pass;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    spad_w_seq_if #(.WEIGHT_DW(WEIGHT_DW), .AW(AW)) bus ();

    spad_w_seq #(
        .WEIGHT_DW (WEIGHT_DW),
        .DEPTH     (DEPTH),
        .PASS_W    (PASS_W),
        .AW        (AW)
    ) dut (
        .sclk     (sclk),
        .rst      (rst),
        .start    (start),
        .num_w    (num_w),
        .num_pass (num_pass),
        .bus      (bus),
        .busy     (busy),
        .done     (done)
    );

    always #5 sclk = ~sclk;

    // Behavioural SPAD_W: commits on negedge, combinational read.
    logic [WEIGHT_DW-1:0] spad_mem [DEPTH];
    always @(negedge sclk) begin
        if (bus.spad_we_en) spad_mem[bus.spad_addr_we] <= bus.spad_data_in;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] ctrl_now();
        return {busy, done, bus.w_ready, bus.spad_we_en, bus.spad_addr_we,
                bus.pe_valid, bus.spad_addr_re, bus.pe_last};
    endfunction

    // vmode: 0 always valid, 1 toggling 1,0,1,..., 2 random
    // rmode: 0 always ready, 1 three stall cycles at weight index 2, 2 random
    // rst_at: reset while the model is at this read index (-1 = never)
    // base: weights base..base+DEPTH-1, or random when negative
    task automatic run_txn(input int nw, input int np, input int vmode, input int rmode,
                           input bit inj, input int rst_at, input int base,
                           output int o_wr, output int o_rd, output int o_done_cyc);
        int n, p, total, wc, rc, stall, post;
        bit fin, aborted, injected, rd_phase, do_rst;
        bit e_busy, e_done, e_wrdy, e_we, e_pv, e_last;
        logic [AW-1:0] e_awe, e_are;
        logic [WEIGHT_DW-1:0] e_wdata;
        logic [WEIGHT_DW-1:0] wt [DEPTH];

        n     = (nw > DEPTH) ? DEPTH : nw;
        p     = (np == 0) ? 1 : np;
        total = n * p;
        for (int i = 0; i < DEPTH; i++) wt[i] = (base >= 0) ? WEIGHT_DW'(base + i) : WEIGHT_DW'($urandom);
        wc = 0; rc = 0; stall = 0; post = 0;
        fin = 0; aborted = 0; injected = 0;
        o_done_cyc = -2;

        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge sclk); #1;
            rst    = 1'b0;
            do_rst = 1'b0;
            if (cyc == 0) begin
                start    = 1'b1;
                num_w    = nw[AW:0];
                num_pass = np[PASS_W-1:0];
            end else begin
                start    = 1'b0;
                num_w    = (AW+1)'($urandom);
                num_pass = PASS_W'($urandom);
            end
            rd_phase = (cyc >= 1) && !aborted && !fin && (wc == n) && (rc < total);
            if (inj && !injected && rd_phase && rc == 1) begin
                start    = 1'b1;
                injected = 1'b1;
            end
            if (rst_at >= 0 && rd_phase && rc == rst_at) begin
                rst    = 1'b1;
                do_rst = 1'b1;
            end
            case (vmode)
                0:       bus.w_valid = 1'b1;
                1:       bus.w_valid = (cyc % 2) == 1;
                default: bus.w_valid = ($urandom_range(0, 2) != 0);
            endcase
            bus.w_data = (wc < DEPTH) ? wt[wc] : WEIGHT_DW'($urandom);
            case (rmode)
                0: bus.pe_ready = 1'b1;
                1: begin
                    if (rd_phase && rc == 2 && stall < 3) begin
                        bus.pe_ready = 1'b0;
                        stall++;
                    end else begin
                        bus.pe_ready = 1'b1;
                    end
                end
                default: bus.pe_ready = ($urandom_range(0, 3) != 0);
            endcase
            #3;

            e_busy = (cyc >= 1) && !fin && !aborted;
            e_wrdy = e_busy && (wc < n);
            e_we   = e_wrdy && bus.w_valid;
            e_pv   = e_busy && (wc == n) && (rc < total);
            e_done = e_busy && (wc == n) && (rc == total);
            e_last = e_pv && (rc == total - 1);
            e_awe  = e_wrdy ? AW'(wc) : '0;
            e_are  = '0;
            if (e_pv) e_are = AW'(rc % n);
            e_wdata = e_wrdy ? wt[wc] : '0;

            check($sformatf("ctrl cyc%0d", cyc), 64'(ctrl_now()),
                  64'({e_busy, e_done, e_wrdy, e_we, e_awe, e_pv, e_are, e_last}));
            check($sformatf("wdata cyc%0d", cyc), 64'(bus.spad_data_in), 64'(e_wdata));
            if (e_pv && bus.pe_ready && bus.pe_valid)
                check($sformatf("pe_data cyc%0d idx%0d", cyc, rc), 64'(spad_mem[bus.spad_addr_re]), 64'(wt[rc % n]));

            if (aborted) begin
                post++;
                if (post >= 3) break;
            end else if (fin) begin
                break;
            end else begin
                if (do_rst) begin
                    aborted = 1'b1;
                end else begin
                    if (e_wrdy && bus.w_valid) wc++;
                    if (e_pv && bus.pe_ready) rc++;
                    if (e_done) begin
                        fin        = 1'b1;
                        o_done_cyc = cyc;
                    end
                end
            end
        end
        if (!fin && !aborted) begin
            checks++;
            failures++;
            $display("FAIL timeout: got no done within budget, required done");
        end
        o_wr = wc;
        o_rd = rc;
    endtask

    typedef struct {
        int nw; int np; int vmode; int rmode; bit inj; int rst_at; int base;
        int exp_wr; int exp_rd; int exp_done;
    } vec_t;

    vec_t vecs [10];
    int   g_wr, g_rd, g_dc;

    initial begin
        vecs[0] = '{4,  2, 0, 0, 1'b0, -1, 10,    4,  8, 13};
        vecs[1] = '{3,  1, 1, 0, 1'b0, -1, 100,   3,  3,  9};
        vecs[2] = '{4,  1, 0, 1, 1'b0, -1, 200,   4,  4, 12};
        vecs[3] = '{0,  3, 0, 0, 1'b0, -1, 300,   0,  0,  1};
        vecs[4] = '{12, 2, 0, 0, 1'b0, -1, 400,   8, 16, 25};
        vecs[5] = '{2,  0, 0, 0, 1'b0, -1, 500,   2,  2,  5};
        vecs[6] = '{3,  2, 0, 0, 1'b1, -1, 600,   3,  6, 10};
        vecs[7] = '{5,  3, 0, 0, 1'b0,  4, 700,   5,  4, -2};
        vecs[8] = '{4,  2, 0, 0, 1'b0, -1, 800,   4,  8, 13};
        vecs[9] = '{8,  1, 0, 0, 1'b0, -1, 900,   8,  8, 17};

        rst = 1'b1; start = 1'b0; num_w = '0; num_pass = '0;
        bus.w_valid = 1'b1; bus.w_data = 32'hdead_beef; bus.pe_ready = 1'b1;
        repeat (3) @(posedge sclk);
        #4;
        check("reset ctrl", 64'(ctrl_now()), 64'(0));
        check("reset wdata", 64'(bus.spad_data_in), 64'(0));
        @(posedge sclk); #1;
        rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            run_txn(vecs[v].nw, vecs[v].np, vecs[v].vmode, vecs[v].rmode, vecs[v].inj,
                    vecs[v].rst_at, vecs[v].base, g_wr, g_rd, g_dc);
            check($sformatf("vec%0d writes", v), 64'(g_wr), 64'(vecs[v].exp_wr));
            check($sformatf("vec%0d reads", v), 64'(g_rd), 64'(vecs[v].exp_rd));
            check($sformatf("vec%0d done_cycle", v), 64'(g_dc), 64'(vecs[v].exp_done));
        end

        for (int r = 0; r < 8; r++) begin
            int nw, np, n, p;
            nw = $urandom_range(0, 15);
            np = $urandom_range(0, 4);
            n  = (nw > DEPTH) ? DEPTH : nw;
            p  = (np == 0) ? 1 : np;
            run_txn(nw, np, 2, 2, 1'b0, -1, -1, g_wr, g_rd, g_dc);
            check($sformatf("rand%0d writes", r), 64'(g_wr), 64'(n));
            check($sformatf("rand%0d reads", r), 64'(g_rd), 64'(n * p));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
